btn_conditioner: RTL
====================

# btn_conditioner

Front-end conditioning stage for the range-hood control panel. It sits directly upstream of the top-level control logic and converts the five raw push buttons (up, left, middle, right, down) into clean signals for the mode FSM, on/off control, time adjust and gesture logic. Each button gets a two-flop synchroniser, a debounce filter, and a single-cycle press pulse. It also classifies each press as short or long and, optionally, auto-repeats while a button is held.

## Interface
Parameters:
- N_BTN, 5, number of buttons; bit order 0=up, 1=left, 2=middle, 3=right, 4=down
- DEB_CYC, 2_000_000, consecutive stable cycles required to accept a level change (20 ms at 100 MHz)
- LONG_CYC, 300_000_000, hold cycles after acceptance before a long press fires (3 s)
- REP_START_CYC, 50_000_000, hold cycles before the first auto-repeat pulse
- REP_CYC, 20_000_000, cycles between subsequent auto-repeat pulses

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- btn_raw  in  N_BTN  asynchronous raw button inputs, 1 = pressed
- btn_level  out  N_BTN  debounced level
- btn_pulse  out  N_BTN  one-cycle press pulse, plus auto-repeat pulses when enabled
- btn_short  out  N_BTN  one-cycle pulse on release, only if btn_long did not fire for that press
- btn_long  out  N_BTN  one-cycle pulse when the hold time reaches LONG_CYC

## Operation
- Buttons are fully independent. There is one identical channel per bit and no priority between channels.
- Synchroniser: two flops per bit. Both reset to 0.
- Debounce: a counter of width $clog2(DEB_CYC+1) counts cycles in which the sync output differs from btn_level.
  - The counter clears on any cycle where they match.
  - When the count reaches DEB_CYC, btn_level toggles and the counter clears.
- Per-channel FSM:
  - IDLE: level 0.
  - PRESSED: level 1, hold counter running.
  - LONG: level 1, long already fired.
  - IDLE->PRESSED when the debounced level rises. btn_pulse is 1 in that same cycle. The hold counter h is set to 0.
  - In PRESSED and LONG, h increments each cycle and saturates at LONG_CYC.
  - PRESSED->LONG when h reaches LONG_CYC. btn_long is 1 in that cycle.
  - PRESSED->IDLE on a debounced fall. btn_short is 1 in that cycle.
  - LONG->IDLE on a debounced fall. No output pulse.
- Auto-repeat (macro enabled): btn_pulse also fires at h = REP_START_CYC, then every REP_CYC cycles while held, in either PRESSED or LONG.
  - The repeat counter is separate from h and is not affected by h saturating.
- Counter widths are $clog2 of the maximum count plus 1. No counter wraps.

## Timing
- Reset values: btn_level = 0, btn_pulse = 0, btn_short = 0, btn_long = 0. All counters are 0 and every FSM is in IDLE.
- Press latency: a raw edge at cycle t, held stable, changes btn_level at cycle t+2+DEB_CYC. btn_pulse or btn_short is asserted in that same cycle.
- Long press: btn_long fires LONG_CYC cycles after btn_pulse.
- Glitch rejection: a raw pulse shorter than DEB_CYC cycles produces no output change. Its debounce count is discarded.
- A release whose debounced fall lands exactly on the cycle where h would reach LONG_CYC counts as a release. The result is btn_short with no btn_long.
- Reset mid-hold: all outputs drop to 0 in the cycle after rst is sampled high. A button still held after rst deasserts produces a fresh btn_pulse 2+DEB_CYC cycles later.
- All pulse outputs are registered. Each lasts exactly one cycle.

## Configuration
- Macro: BTN_AUTOREPEAT_EN.
- Defined: the auto-repeat pulses described above are generated on btn_pulse.
- Undefined: btn_pulse fires exactly once per accepted press. REP_START_CYC and REP_CYC are ignored, and no repeat counter is synthesised.

## Test plan
All scenarios use DEB_CYC=4, LONG_CYC=20, REP_START_CYC=10, REP_CYC=5.
- Clean short press: btn_raw[0] rises at cycle 0 and falls at cycle 10.
  - btn_level[0] rises at cycle 6, with btn_pulse[0] at 6.
  - btn_level[0] falls at cycle 16, with btn_short[0] at 16.
  - btn_long[0] never fires.
- Bounce: btn_raw[2] toggles 1,0,1,0 with 2-cycle dwell, then stays 0.
  - All outputs stay 0.
- Long hold: btn_raw[1] is high from cycle 0 to cycle 40.
  - btn_pulse[1] at 6, btn_long[1] at 26.
  - btn_level[1] falls at 46 with no btn_short.
- Auto-repeat (macro defined), btn_raw[3] held from cycle 0:
  - btn_pulse[3] at 6, 16, 21, 26, 31, …
  - With the macro undefined: only at 6.
- Reset mid-hold: btn_raw[4] is held. rst is high for cycles 12–13 and low from cycle 14.
  - All outputs are 0 from cycle 13.
  - btn_pulse[4] fires again at 20.
- Simultaneous: btn_raw[0] and btn_raw[4] rise together at cycle 0.
  - Both btn_pulse bits fire at 6.
  - Releasing only bit 0 gives btn_short[0] only; bit 4 is unaffected.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Raw button inputs and conditioned button outputs for btn_conditioner.
// master drives btn_raw and observes the conditioned outputs; slave is the conditioner side.
interface btn_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_short;
  logic [N_BTN-1:0] btn_long;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  btn_short,
    input  btn_long
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output btn_short,
    output btn_long
  );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button sync + debounce + press/short/long classification; auto-repeat on btn_pulse when BTN_AUTOREPEAT_EN is defined.
// Raw edge to btn_level is 2+DEB_CYC cycles, pulses registered alongside the level; no backpressure, all pulses last one cycle.
module btn_conditioner #(
  parameter int N_BTN         = 5,
  parameter int DEB_CYC       = 2_000_000,
  parameter int LONG_CYC      = 300_000_000,
  parameter int REP_START_CYC = 50_000_000,
  parameter int REP_CYC       = 20_000_000
) (
  input  logic           clk,
  input  logic           rst,
  btn_conditioner_if.slave bus
);

  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam int H_W   = $clog2(LONG_CYC + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [H_W-1:0]   H_MAX    = H_W'(LONG_CYC);
  localparam logic [H_W-1:0]   H_PRE    = H_W'(LONG_CYC - 1);

  if (DEB_CYC < 1 || LONG_CYC < 1 || REP_START_CYC < 1 || REP_CYC < 1) begin : g_param_check
    $error("btn_conditioner: cycle-count parameters must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_e;

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] short_q, short_d;
  logic [N_BTN-1:0] long_q,  long_d;
  logic [N_BTN-1:0] rise, fall;

  logic [DEB_W-1:0] deb_cnt_q [N_BTN];
  logic [DEB_W-1:0] deb_cnt_d [N_BTN];
  state_e           state_q   [N_BTN];
  state_e           state_d   [N_BTN];
  logic [H_W-1:0]   hold_q    [N_BTN];
  logic [H_W-1:0]   hold_d    [N_BTN];

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_START_CYC > REP_CYC) ? REP_START_CYC : REP_CYC;
  localparam int R_W     = $clog2(REP_MAX + 1);
  localparam logic [R_W-1:0] R_FIRST = R_W'(REP_START_CYC - 1);
  localparam logic [R_W-1:0] R_NEXT  = R_W'(REP_CYC - 1);

  logic [R_W-1:0]   rep_q [N_BTN];
  logic [R_W-1:0]   rep_d [N_BTN];
  logic [N_BTN-1:0] rep_arm_q, rep_arm_d;
  logic [N_BTN-1:0] rep_hit;
`endif

  // Debounce: level flips only after DEB_CYC consecutive disagreeing samples.
  always_comb begin
    sync1_d = bus.btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = level_q & ~level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      short_q <= '0;
      long_q  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_q[i] <= '0;
        state_q[i]   <= S_IDLE;
        hold_q[i]    <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rep_q[i]     <= '0;
`endif
      end
`ifdef BTN_AUTOREPEAT_EN
      rep_arm_q <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      short_q <= short_d;
      long_q  <= long_d;
      for (int i = 0; i < N_BTN; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        state_q[i]   <= state_d[i];
        hold_q[i]    <= hold_d[i];
`ifdef BTN_AUTOREPEAT_EN
        rep_q[i]     <= rep_d[i];
`endif
      end
`ifdef BTN_AUTOREPEAT_EN
      rep_arm_q <= rep_arm_d;
`endif
    end
  end

  // A fall always wins over reaching LONG_CYC, so a release on that cycle is short.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = '0;
      case (state_q[i])
        S_IDLE: begin
          if (rise[i]) state_d[i] = S_PRESSED;
        end
        S_PRESSED: begin
          if (fall[i]) begin
            state_d[i] = S_IDLE;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
            if (hold_q[i] == H_PRE) state_d[i] = S_LONG;
          end
        end
        S_LONG: begin
          if (fall[i]) begin
            state_d[i] = S_IDLE;
          end else begin
            hold_d[i] = (hold_q[i] == H_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Repeat counter runs independently of the saturating hold counter.
  always_comb begin
    rep_hit   = '0;
    rep_arm_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_d[i] = '0;
      if (state_q[i] != S_IDLE && !fall[i]) begin
        rep_hit[i] = (rep_q[i] == (rep_arm_q[i] ? R_NEXT : R_FIRST));
        if (rep_hit[i]) begin
          rep_arm_d[i] = 1'b1;
        end else begin
          rep_d[i]     = rep_q[i] + 1'b1;
          rep_arm_d[i] = rep_arm_q[i];
        end
      end
    end
  end
`endif

  always_comb begin
    pulse_d = '0;
    short_d = '0;
    long_d  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      pulse_d[i] = (state_q[i] == S_IDLE) && rise[i];
      short_d[i] = (state_q[i] == S_PRESSED) && fall[i];
      long_d[i]  = (state_q[i] == S_PRESSED) && !fall[i] && (hold_q[i] == H_PRE);
    end
`ifdef BTN_AUTOREPEAT_EN
    pulse_d = pulse_d | rep_hit;
`endif
  end

  assign bus.btn_level = level_q;
  assign bus.btn_pulse = pulse_q;
  assign bus.btn_short = short_q;
  assign bus.btn_long  = long_q;

endmodule
